// File: rtl/layer_sequencer.sv
// Layer descriptor sequencer: fetches 64-bit descriptors from instruction RAM, issues them
// one at a time to the neuron-unit array and exposes run/continuous/progress registers.
module layer_sequencer #(
  parameter int         INST_MEM_DEPTH = 9,
  parameter int         LAYER_WIDTH    = 64,
  parameter int         MM_DEPTH       = 16,
  parameter int         MM_WIDTH       = 16,
  parameter logic [2:0] STATUS_REGION  = 3'b110
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MM_DEPTH-1:0]       mm_address,
  input  logic                      mm_write,
  input  logic [MM_WIDTH-1:0]       mm_writedata,
  input  logic                      mm_read,
  output logic [MM_WIDTH-1:0]       mm_readdata,
  output logic [INST_MEM_DEPTH-1:0] inst_addr,
  input  logic [LAYER_WIDTH-1:0]    inst_data,
  output logic [LAYER_WIDTH-1:0]    layer,
  output logic                      layer_valid,
  input  logic                      layer_ready,
  input  logic                      layer_done,
  output logic                      program_done,
  output logic                      busy,
  output logic [2:0]                fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_END    = 3'd5
  } state_t;

  localparam logic [INST_MEM_DEPTH-1:0] PC_LAST = {INST_MEM_DEPTH{1'b1}};
  localparam logic [INST_MEM_DEPTH-1:0] PC_ONE  = INST_MEM_DEPTH'(1);

  state_t                    state;
  logic [INST_MEM_DEPTH-1:0] pc;
  logic                      run;
  logic                      continuous;
  logic [15:0]               completed;

  logic                      in_region;
  logic                      reg_write;
  logic [MM_WIDTH-1:0]       rd_val;
  logic                      dec_term;
  logic                      dec_empty;
  logic                      unused_bits;

  // The RAM has one cycle of read latency, so the address is simply the pc:
  // whatever pc holds during FETCH is the word that shows up in DECODE.
  assign inst_addr = pc;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  assign in_region   = (mm_address[MM_DEPTH-1 -: 3] == STATUS_REGION);
  assign reg_write   = mm_write && in_region && (mm_address[1:0] == 2'd0);
  assign dec_term    = inst_data[LAYER_WIDTH-1];
  assign dec_empty   = (inst_data[27:16] == 12'd0) || (inst_data[15:4] == 12'd0);
  assign unused_bits = ^{mm_address[MM_DEPTH-4:2], mm_writedata[MM_WIDTH-1:2]};

  always_comb begin
    rd_val = '0;
    case (mm_address[1:0])
      2'd0:    rd_val = MM_WIDTH'({busy, continuous, run});
      2'd1:    rd_val = MM_WIDTH'(pc);
      2'd2:    rd_val = MM_WIDTH'(completed);
      default: rd_val = '0;
    endcase
  end

  // Handshake: layer/layer_valid are registered; once layer_valid rises, layer holds
  // until a cycle with layer_valid && layer_ready, which is the single transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      run          <= 1'b0;
      continuous   <= 1'b0;
      completed    <= '0;
      layer        <= '0;
      layer_valid  <= 1'b0;
      program_done <= 1'b0;
      mm_readdata  <= '0;
    end else begin
      program_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          layer <= inst_data;
          if (!run) begin
            state <= S_IDLE;
          end else if (dec_term) begin
            state        <= S_END;
            program_done <= 1'b1;
          end else if (dec_empty) begin
            if (pc == PC_LAST) begin
              state        <= S_END;
              program_done <= 1'b1;
            end else begin
              pc    <= pc + PC_ONE;
              state <= S_FETCH;
            end
          end else begin
            layer_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (layer_ready) begin
            layer_valid <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (layer_done) begin
            if (!run) begin
              state <= S_IDLE;
            end else if (pc == PC_LAST) begin
              state        <= S_END;
              program_done <= 1'b1;
            end else begin
              pc    <= pc + PC_ONE;
              state <= S_FETCH;
            end
          end
        end
        S_END: begin
          completed <= completed + 16'd1;
          if (continuous) begin
            pc    <= '0;
            state <= S_FETCH;
          end else begin
            run   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Placed after the FSM so a software write beats END clearing run.
      if (reg_write) begin
        run        <= mm_writedata[0];
        continuous <= mm_writedata[1];
      end

      if (mm_read) begin
        mm_readdata <= in_region ? rd_val : '0;
      end
    end
  end

endmodule
